// File: rtl/matrix_add_seq_pkg.sv
// matrix_add_seq_pkg: shared FSM encoding, saturation limits and opcode meaning for matrix_add_seq
package matrix_add_seq_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
  localparam logic [7:0] SAT_MAX = 8'h7F;
  localparam logic [7:0] SAT_MIN = 8'h80;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/matrix_add_seq_adder.sv
// matrix_add_seq_adder: 8-bit ripple-carry adder used as the element datapath
module matrix_add_seq_adder (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] sum_o,
  output logic       cout_o
);
  logic [8:0] c;
  assign c[0] = cin_i;
  for (genvar g = 0; g < 8; g++) begin : g_fa
    assign sum_o[g] = a_i[g] ^ b_i[g] ^ c[g];
    assign c[g+1]   = (a_i[g] & b_i[g]) | (c[g] & (a_i[g] ^ b_i[g]));
  end
  assign cout_o = c[8];
endmodule

// File: rtl/matrix_add_seq.sv
// matrix_add_seq: sequential element-wise NxN signed add/subtract, one element per clock
module matrix_add_seq
  import matrix_add_seq_pkg::*;
#(
  parameter int N   = 5,
  parameter int W   = 8,
  parameter bit SAT = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         op_sub,
  input  logic [N*N*W-1:0]             mat_a,
  input  logic [N*N*W-1:0]             mat_b,
  output logic                         busy,
  output logic                         done,
  output logic [N*N*W-1:0]             result,
  output logic                         overflow,
  output logic [$clog2(N*N+1)-1:0]     ovf_count
);
  localparam int NE = N * N;
  localparam int CW = $clog2(NE + 1);
  localparam int IW = (NE > 1) ? $clog2(NE) : 1;
  state_e          state_q;
  logic [IW-1:0]   idx_q;
  logic [NE*W-1:0] a_q, b_q, result_q;
  logic            sub_q, busy_q, done_q, ovf_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    r1, r2, sum, elem_d;
  logic            ovf_d, carry_unused;
  assign r1 = a_q[idx_q*W +: W];
  assign r2 = (sub_q == OP_SUB) ? ~b_q[idx_q*W +: W] : b_q[idx_q*W +: W];
  matrix_add_seq_adder u_adder (
    .a_i   (r1),
    .b_i   (r2),
    .cin_i (sub_q),
    .sum_o (sum),
    .cout_o(carry_unused)
  );
  // Overflow is judged on the adder operands, so subtraction uses the inverted B
  assign ovf_d  = (r1[W-1] == r2[W-1]) && (sum[W-1] != r1[W-1]);
  assign elem_d = (SAT && ovf_d) ? (r1[W-1] ? SAT_MIN : SAT_MAX) : sum;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q      <= mat_a;
            b_q      <= mat_b;
            sub_q    <= op_sub;
            result_q <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          result_q[idx_q*W +: W] <= elem_d;
          if (ovf_d) begin
            ovf_q <= 1'b1;
            cnt_q <= cnt_q + CW'(1);
          end
          if (idx_q == IW'(NE - 1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign ovf_count = cnt_q;
endmodule

// File: tb/tb_matrix_add_seq.sv
// tb_matrix_add_seq: randomized and directed checks of matrix_add_seq against an integer reference model
module tb_matrix_add_seq;
  localparam int N  = 5;
  localparam int W  = 8;
  localparam int NE = N * N;
  localparam int NB = NE * W;
  localparam int CW = $clog2(NE + 1);
  logic clk = 1'b0;
  logic reset, start, op_sub;
  logic [NB-1:0] mat_a, mat_b;
  logic busy0, done0, ovf0, busy1, done1, ovf1;
  logic [NB-1:0] res0, res1;
  logic [CW-1:0] cnt0, cnt1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  matrix_add_seq #(.N(N), .W(W), .SAT(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .start(start), .op_sub(op_sub), .mat_a(mat_a), .mat_b(mat_b),
    .busy(busy0), .done(done0), .result(res0), .overflow(ovf0), .ovf_count(cnt0)
  );
  matrix_add_seq #(.N(N), .W(W), .SAT(1'b1)) u_sat (
    .clk(clk), .reset(reset), .start(start), .op_sub(op_sub), .mat_a(mat_a), .mat_b(mat_b),
    .busy(busy1), .done(done1), .result(res1), .overflow(ovf1), .ovf_count(cnt1)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [NB-1:0] rand_mat();
    logic [NB-1:0] r;
    for (int i = 0; i < NE; i++) r[i*W +: W] = W'($urandom);
    return r;
  endfunction
  // Reference: plain signed integer arithmetic per element, then wrap or clamp
  function automatic logic [NB-1:0] model(input logic [NB-1:0] a, input logic [NB-1:0] b,
                                          input logic sub, input bit sat, output int novf);
    logic [NB-1:0] r;
    int ea, eb, v;
    r = '0;
    novf = 0;
    for (int i = 0; i < NE; i++) begin
      ea = int'($signed(a[i*W +: W]));
      eb = int'($signed(b[i*W +: W]));
      v = sub ? ea - eb : ea + eb;
      if (v > 127 || v < -128) begin
        novf++;
        if (sat) v = (v > 127) ? 127 : -128;
      end
      r[i*W +: W] = v[W-1:0];
    end
    return r;
  endfunction
  // Latch edge counts as edge 1; operands are scrambled right after it
  task automatic run_op(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic sub,
                        output int edges, output bit busy_ok);
    mat_a = a;
    mat_b = b;
    op_sub = sub;
    start = 1'b1;
    tick();
    start = 1'b0;
    mat_a = rand_mat();
    mat_b = rand_mat();
    op_sub = ~sub;
    edges = 1;
    busy_ok = 1'b1;
    while (!done0 && edges < 60) begin
      if (busy0 !== 1'b1) busy_ok = 1'b0;
      tick();
      edges++;
    end
    if (busy0 !== 1'b1) busy_ok = 1'b0;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({busy0, done0, ovf0, busy1, done1, ovf1} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, expected 000000", {busy0, done0, ovf0, busy1, done1, ovf1});
    end
    checks++;
    if (res0 !== '0 || res1 !== '0) begin
      errors++;
      $display("FAIL reset_result: got %h / %h, expected 0", res0, res1);
    end
    checks++;
    if (cnt0 !== '0 || cnt1 !== '0) begin
      errors++;
      $display("FAIL reset_count: got %0d / %0d, expected 0", cnt0, cnt1);
    end
    reset = 1'b0;
    tick();
  endtask
  task automatic test_add;
    logic [NB-1:0] a, b, e0;
    int n0, edges;
    bit bok;
    for (int i = 0; i < NE; i++) begin
      a[i*W +: W] = 8'd3;
      b[i*W +: W] = 8'd4;
    end
    e0 = model(a, b, 1'b0, 1'b0, n0);
    run_op(a, b, 1'b0, edges, bok);
    checks++;
    if (edges !== NE + 1) begin
      errors++;
      $display("FAIL add_latency: got %0d edges, expected %0d", edges, NE + 1);
    end
    checks++;
    if (!bok) begin
      errors++;
      $display("FAIL add_busy: busy dropped before done, expected high");
    end
    checks++;
    if (res0 !== e0 || res1 !== e0) begin
      errors++;
      $display("FAIL add_result: got %h, expected %h", res0, e0);
    end
    checks++;
    if (ovf0 !== 1'b0 || cnt0 !== '0) begin
      errors++;
      $display("FAIL add_ovf: got %b/%0d, expected 0/0", ovf0, cnt0);
    end
    tick();
    checks++;
    if (done0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL add_done_clear: got done=%b busy=%b, expected 0 0", done0, busy0);
    end
  endtask
  task automatic test_sub;
    logic [NB-1:0] a, b, e0;
    int n0, edges;
    bit bok;
    for (int i = 0; i < NE; i++) begin
      a[i*W +: W] = W'(i);
      b[i*W +: W] = 8'd10;
    end
    e0 = model(a, b, 1'b1, 1'b0, n0);
    run_op(a, b, 1'b1, edges, bok);
    checks++;
    if (edges !== NE + 1 || !bok) begin
      errors++;
      $display("FAIL sub_timing: got %0d edges busy_ok=%b, expected %0d 1", edges, bok, NE + 1);
    end
    checks++;
    if (res0 !== e0) begin
      errors++;
      $display("FAIL sub_result: got %h, expected %h", res0, e0);
    end
    checks++;
    if (res0[7:0] !== 8'hF6 || res0[NB-1 -: 8] !== 8'd14) begin
      errors++;
      $display("FAIL sub_ends: got %h %h, expected f6 0e", res0[7:0], res0[NB-1 -: 8]);
    end
    checks++;
    if (ovf0 !== 1'b0) begin
      errors++;
      $display("FAIL sub_ovf: got %b, expected 0", ovf0);
    end
    tick();
  endtask
  task automatic test_overflow;
    logic [NB-1:0] a, b, e0, e1;
    int n0, n1, edges;
    bit bok;
    a = '0;
    b = '0;
    a[7:0] = 8'd100;
    b[7:0] = 8'd100;
    a[63:56] = 8'h80;
    b[63:56] = 8'hFF;
    e0 = model(a, b, 1'b0, 1'b0, n0);
    e1 = model(a, b, 1'b0, 1'b1, n1);
    run_op(a, b, 1'b0, edges, bok);
    checks++;
    if (edges !== NE + 1 || !bok) begin
      errors++;
      $display("FAIL ovf_timing: got %0d edges busy_ok=%b, expected %0d 1", edges, bok, NE + 1);
    end
    checks++;
    if (res0 !== e0 || res0[7:0] !== 8'hC8 || res0[63:56] !== 8'h7F) begin
      errors++;
      $display("FAIL ovf_wrap_result: got %h, expected %h", res0, e0);
    end
    checks++;
    if (res1 !== e1 || res1[7:0] !== 8'h7F || res1[63:56] !== 8'h80) begin
      errors++;
      $display("FAIL ovf_sat_result: got %h, expected %h", res1, e1);
    end
    checks++;
    if (ovf0 !== 1'b1 || ovf1 !== 1'b1 || cnt0 !== CW'(2) || cnt1 !== CW'(2)) begin
      errors++;
      $display("FAIL ovf_flags: got %b/%0d %b/%0d, expected 1/2 1/2", ovf0, cnt0, ovf1, cnt1);
    end
    tick();
  endtask
  task automatic test_random;
    logic [NB-1:0] a, b, e0, e1;
    logic s;
    int n0, n1, edges;
    bit bok;
    for (int k = 0; k < 4; k++) begin
      a = rand_mat();
      b = rand_mat();
      s = 1'($urandom);
      e0 = model(a, b, s, 1'b0, n0);
      e1 = model(a, b, s, 1'b1, n1);
      run_op(a, b, s, edges, bok);
      checks++;
      if (edges !== NE + 1 || !bok) begin
        errors++;
        $display("FAIL rand%0d_timing: got %0d edges busy_ok=%b, expected %0d 1", k, edges, bok, NE + 1);
      end
      checks++;
      if (res0 !== e0) begin
        errors++;
        $display("FAIL rand%0d_wrap: got %h, expected %h", k, res0, e0);
      end
      checks++;
      if (res1 !== e1) begin
        errors++;
        $display("FAIL rand%0d_sat: got %h, expected %h", k, res1, e1);
      end
      checks++;
      if (cnt0 !== CW'(n0) || cnt1 !== CW'(n1) || ovf0 !== (n0 != 0) || ovf1 !== (n1 != 0)) begin
        errors++;
        $display("FAIL rand%0d_ovf: got %b/%0d %b/%0d, expected count %0d", k, ovf0, cnt0, ovf1, cnt1, n0);
      end
      tick();
    end
  endtask
  task automatic test_back_to_back;
    logic [NB-1:0] a1, a2, a3, b, e1, e2;
    logic s;
    int n, edges;
    a1 = rand_mat();
    a2 = rand_mat();
    a3 = rand_mat();
    b = rand_mat();
    s = 1'($urandom);
    e1 = model(a1, b, s, 1'b0, n);
    e2 = model(a2, b, s, 1'b0, n);
    mat_a = a1;
    mat_b = b;
    op_sub = s;
    start = 1'b1;
    tick();
    mat_a = a2;
    edges = 1;
    while (!done0 && edges < 60) begin
      tick();
      edges++;
    end
    checks++;
    if (edges !== NE + 1 || res0 !== e1) begin
      errors++;
      $display("FAIL b2b_first: got %0d edges result %h, expected %0d %h", edges, res0, NE + 1, e1);
    end
    tick();
    checks++;
    if (done0 !== 1'b0 || busy0 !== 1'b0 || done1 !== done0) begin
      errors++;
      $display("FAIL b2b_idle_gap: got done=%b busy=%b, expected 0 0", done0, busy0);
    end
    tick();
    mat_a = a3;
    checks++;
    if (busy0 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_relatch: got busy=%b, expected 1", busy0);
    end
    edges = 1;
    while (!done0 && edges < 60) begin
      tick();
      edges++;
    end
    start = 1'b0;
    checks++;
    if (edges !== NE + 1 || res0 !== e2) begin
      errors++;
      $display("FAIL b2b_second: got %0d edges result %h, expected %0d %h", edges, res0, NE + 1, e2);
    end
    tick();
    tick();
  endtask
  task automatic test_reset_mid_run;
    logic [NB-1:0] a, b, e0;
    int n0, edges;
    bit bok, seen;
    mat_a = rand_mat();
    mat_b = rand_mat();
    op_sub = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (12) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || ovf0 !== 1'b0 || cnt0 !== '0) begin
      errors++;
      $display("FAIL abort_flags: got busy=%b done=%b ovf=%b cnt=%0d, expected all 0", busy0, done0, ovf0, cnt0);
    end
    checks++;
    if (res0 !== '0) begin
      errors++;
      $display("FAIL abort_result: got %h, expected 0", res0);
    end
    seen = 1'b0;
    repeat (30) begin
      tick();
      if (done0 !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_no_done: got a done pulse, expected none");
    end
    a = rand_mat();
    b = rand_mat();
    e0 = model(a, b, 1'b1, 1'b0, n0);
    run_op(a, b, 1'b1, edges, bok);
    checks++;
    if (edges !== NE + 1 || !bok || res0 !== e0 || cnt0 !== CW'(n0)) begin
      errors++;
      $display("FAIL abort_recover: got %0d edges result %h cnt %0d, expected %0d %h %0d",
               edges, res0, cnt0, NE + 1, e0, n0);
    end
    tick();
  endtask
  initial begin
    reset = 1'b1;
    start = 1'b0;
    op_sub = 1'b0;
    mat_a = '0;
    mat_b = '0;
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/matrix_add_seq.md
Name: matrix_add_seq

Overview:
Sequential element-wise matrix add/subtract engine for the coprocessor datapath. It sits directly upstream of the 8-bit ripple adder stage and owns that adder's operands and carry-in.
- Latches two flattened NxN signed 8-bit matrices.
- Walks them one element per clock through a single adder instance.
- Collects the sums into a result register, with a per-operation overflow flag and optional saturation.
- Consumed by the instruction-issue controller through a start/busy/done handshake.

Parameters:
- N, 5, matrix dimension (N*N elements, row-major, element 0 at bits [7:0]).
- W, 8, element width in bits; fixed at 8 to match the adder stage.
- SAT, 0, 1 = clamp overflowed elements to +127/-128; 0 = wrap (two's complement).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op_sub  input  1  0 = A+B, 1 = A-B; latched with start.
- mat_a  input  N*N*W  operand A, flattened row-major.
- mat_b  input  N*N*W  operand B, flattened row-major.
- busy  output  1  high from the latch edge until done deasserts.
- done  output  1  one-cycle pulse; result valid from this cycle.
- result  output  N*N*W  element-wise result, held until the next accepted start.
- overflow  output  1  sticky: any element overflowed during the current operation.
- ovf_count  output  $clog2(N*N+1)  number of overflowed elements.

Behaviour:
- One clock (clk). Reset is synchronous and active-high on reset.
- Reset values: busy=0, done=0, result=0, overflow=0, ovf_count=0, idx=0, state=IDLE.
- FSM states:
  - IDLE: if start=1 at an edge, latch mat_a, mat_b and op_sub; clear result, overflow and ovf_count; idx<=0; go to RUN; busy<=1.
  - RUN: each edge writes result[idx] from the adder output and increments idx. At idx=N*N-1 the write happens, then the state goes to DONE.
  - DONE: done=1 and busy=1 for exactly one cycle; the next edge goes to IDLE, done<=0, busy<=0.
- Adder drive:
  - r1 = A[idx].
  - r2 = op_sub ? ~B[idx] : B[idx].
  - cin = op_sub.
  - 8-bit result; the carry-out is ignored for signed results.
- Signed overflow per element: (r1[7]==r2[7]) && (s[7]!=r1[7]).
  - On overflow: overflow<=1 and ovf_count increments.
  - If SAT=1, the stored element is 8'h7F when r1[7]=0, else 8'h80. If SAT=0, the wrapped sum is stored.
- Latency: done rises N*N+1 edges after the edge that sampled start (26 for N=5). Throughput is one operation per N*N+2 cycles.
- start while busy (RUN or DONE) is ignored; no queueing.
- Operand changes after the latch edge have no effect on the current operation.
- start asserted in the same cycle done is high is ignored. It is accepted on the next IDLE cycle if still high.
- reset mid-RUN aborts the operation: all outputs return to reset values on that edge, and no done is issued.
- Partial results are not visible as valid; only the done cycle and the cycles after it define result.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Element saturation constants (SAT_MAX=8'h7F, SAT_MIN=8'h80).
  - Opcode bit meaning for op_sub.
- One natural sub-module: the existing 8-bit ripple adder, instantiated once as the element datapath.
- Element select and result write use indexed part-selects. No other sub-modules.

Test Plan:
- Add with no overflow: A all 8'd3, B all 8'd4, op_sub=0, start one cycle -> done pulses 26 edges later; every result element = 8'd7; overflow=0; ovf_count=0; busy high through done.
- Subtract with negatives: A[i]=i, B[i]=8'd10, op_sub=1 -> result[i]=i-10, e.g. element 0 = 8'hF6 and element 24 = 8'd14; overflow=0.
- Overflow with SAT=0: element 0 = 100+100, element 7 = -128 + -1, rest 0+0 -> result[0]=8'h C8, result[7]=8'h7F; overflow=1; ovf_count=2.
- Same stimulus with SAT=1: result[0]=8'h7F, result[7]=8'h80; ovf_count=2.
- Handshake edges: hold start high continuously and change mat_a mid-RUN -> exactly one done per N*N+2 cycles; each result reflects only the operands latched at its own start.
- Reset mid-RUN: assert reset at idx=12 -> next edge: busy=0, result=0, overflow=0, no done pulse; a following start completes normally.
